// File: rtl/demux_pkg.sv
// demux_chan shared types and defaults.
// Optional error counter: define DEMUX_ERR_CNT_EN.
package demux_pkg;

  typedef enum logic {
    MODE_ADDR = 1'b0,
    MODE_SEQ  = 1'b1
  } demux_mode_t;

  localparam int DEF_DATA_W = 1;
  localparam int DEF_N_CH   = 4;
  localparam int ERR_CNT_W  = 8;

  localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = '1;

  function automatic logic [ERR_CNT_W-1:0] sat_inc(
    input logic [ERR_CNT_W-1:0] v
  );
    return (v == ERR_CNT_MAX) ? v : v + ERR_CNT_W'(1);
  endfunction

endpackage

// File: rtl/demux_chan_if.sv
// Sample/channel bundle between demux_chan and its neighbours.
// outErrCnt exists only when DEMUX_ERR_CNT_EN is defined.
interface demux_chan_if
  import demux_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int N_CH   = DEF_N_CH
);
  localparam int SEL_W = $clog2(N_CH);

  logic [DATA_W-1:0]      inData;
  logic                   inValid;
  demux_mode_t            inMode;
  logic [SEL_W-1:0]       inSel;
  logic                   inSyncClr;
  logic [N_CH*DATA_W-1:0] outData;
  logic [N_CH-1:0]        outValid;
  logic [SEL_W-1:0]       outPtr;
  logic                   outWrap;
  logic                   outErr;
`ifdef DEMUX_ERR_CNT_EN
  logic [ERR_CNT_W-1:0]   outErrCnt;
`endif

  modport master (
    output inData,
    output inValid,
    output inMode,
    output inSel,
    output inSyncClr,
    input  outData,
    input  outValid,
    input  outPtr,
    input  outWrap,
`ifdef DEMUX_ERR_CNT_EN
    input  outErrCnt,
`endif
    input  outErr
  );

  modport slave (
    input  inData,
    input  inValid,
    input  inMode,
    input  inSel,
    input  inSyncClr,
    output outData,
    output outValid,
    output outPtr,
    output outWrap,
`ifdef DEMUX_ERR_CNT_EN
    output outErrCnt,
`endif
    output outErr
  );

endinterface

// File: rtl/demux_seq_ptr.sv
// Round-robin channel pointer with sync clear and wrap pulse.
module demux_seq_ptr
  import demux_pkg::*;
#(
  parameter  int N_CH  = DEF_N_CH,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             adv,
  input  logic             sync_clr,
  output logic [SEL_W-1:0] tgt,
  output logic [SEL_W-1:0] ptr,
  output logic             wrap
);

  localparam logic [SEL_W-1:0] LAST = SEL_W'(N_CH - 1);

  logic [SEL_W-1:0] ptr_q;
  logic [SEL_W-1:0] ptr_d;
  logic [SEL_W-1:0] base;
  logic             wrap_q;
  logic             wrap_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      ptr_q  <= ptr_d;
      wrap_q <= wrap_d;
    end
  end

  // Sync clear redirects the current sample to channel 0 as well.
  always_comb begin
    base   = sync_clr ? '0 : ptr_q;
    ptr_d  = base;
    wrap_d = 1'b0;
    if (adv) begin
      wrap_d = (base == LAST);
      ptr_d  = (base == LAST) ? '0 : base + SEL_W'(1);
    end
  end

  assign tgt  = base;
  assign ptr  = ptr_q;
  assign wrap = wrap_q;

endmodule

// File: rtl/demux_chan.sv
// Registered 1:N sample demultiplexer, addressed or round-robin.
// Define DEMUX_ERR_CNT_EN to add the saturating outErrCnt output.
module demux_chan
  import demux_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int N_CH   = DEF_N_CH
) (
  input logic         inClk,
  input logic         inRst,
  demux_chan_if.slave bus
);

  localparam int SEL_W = $clog2(N_CH);
  localparam logic [SEL_W-1:0] LAST = SEL_W'(N_CH - 1);

  logic                         seq_m;
  logic                         adv;
  logic                         drop;
  logic [SEL_W-1:0]             seq_tgt;
  logic [SEL_W-1:0]             target;
  logic [N_CH-1:0]              wr_en;
  logic [N_CH-1:0][DATA_W-1:0]  ch_q;
  logic [N_CH-1:0]              vld_q;
  logic                         err_q;

  assign seq_m = (bus.inMode == MODE_SEQ);
  assign adv   = bus.inValid && seq_m;
  // Only reachable when N_CH is not a power of two.
  assign drop  = bus.inValid && !seq_m && (bus.inSel > LAST);

  demux_seq_ptr #(
    .N_CH (N_CH)
  ) u_ptr (
    .clk      (inClk),
    .rst      (inRst),
    .adv      (adv),
    .sync_clr (bus.inSyncClr),
    .tgt      (seq_tgt),
    .ptr      (bus.outPtr),
    .wrap     (bus.outWrap)
  );

  always_comb begin
    target = seq_m ? seq_tgt : bus.inSel;
    wr_en  = '0;
    for (int k = 0; k < N_CH; k++) begin
      wr_en[k] = bus.inValid && !drop && (target == SEL_W'(k));
    end
  end

  always_ff @(posedge inClk or posedge inRst) begin
    if (inRst) begin
      ch_q  <= '0;
      vld_q <= '0;
      err_q <= 1'b0;
    end else begin
      vld_q <= wr_en;
      err_q <= drop;
      for (int k = 0; k < N_CH; k++) begin
        if (wr_en[k]) ch_q[k] <= bus.inData;
      end
    end
  end

  assign bus.outData  = ch_q;
  assign bus.outValid = vld_q;
  assign bus.outErr   = err_q;

`ifdef DEMUX_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_cnt_q;

  // Counts alongside the registered outErr pulse.
  always_ff @(posedge inClk or posedge inRst) begin
    if (inRst)     err_cnt_q <= '0;
    else if (drop) err_cnt_q <= sat_inc(err_cnt_q);
  end

  assign bus.outErrCnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_demux_chan.sv
// Scoreboard bench for demux_chan, N_CH=3 DATA_W=3.
module tb_demux_chan;
  import demux_pkg::*;

  logic inClk = 1'b0;
  logic inRst = 1'b1;

  demux_chan_if #(.DATA_W(3), .N_CH(3)) bus();

  demux_chan #(.DATA_W(3), .N_CH(3)) dut (
    .inClk (inClk),
    .inRst (inRst),
    .bus   (bus)
  );

  always #5 inClk = ~inClk;

  typedef struct packed {
    logic [2:0] vld;
    logic [8:0] data;
    logic       wrap;
    logic       err;
    logic [1:0] ptr;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  always @(negedge inClk) begin : monitor
    exp_t a;
    exp_t e;
    if (!inRst && (bus.outValid != 3'b000 || bus.outErr)) begin
      a = '{bus.outValid, bus.outData, bus.outWrap, bus.outErr, bus.outPtr};
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_out got=%h", a);
      end else begin
        e = q.pop_front();
        if (a !== e) begin
          bad++;
          $display("FAIL out got vld=%b data=%b wrap=%b err=%b ptr=%0d want vld=%b data=%b wrap=%b err=%b ptr=%0d",
                   a.vld, a.data, a.wrap, a.err, a.ptr,
                   e.vld, e.data, e.wrap, e.err, e.ptr);
        end
      end
    end
  end

  task automatic send(input demux_mode_t m, input logic [1:0] sel,
                      input logic [2:0] d, input logic sc,
                      input logic [2:0] ev, input logic [8:0] ed,
                      input logic ew, input logic ee,
                      input logic [1:0] ep);
    @(posedge inClk);
    #1;
    bus.inMode    = m;
    bus.inSel     = sel;
    bus.inData    = d;
    bus.inSyncClr = sc;
    bus.inValid   = 1'b1;
    q.push_back('{ev, ed, ew, ee, ep});
  endtask

  task automatic quiet();
    @(posedge inClk);
    #1;
    bus.inValid   = 1'b0;
    bus.inSyncClr = 1'b0;
  endtask

  task automatic idle(input logic sc, input logic [1:0] ep);
    @(posedge inClk);
    #1;
    bus.inValid   = 1'b0;
    bus.inSyncClr = sc;
    @(posedge inClk);
    @(negedge inClk);
    chk("idle_ptr", 32'(bus.outPtr), 32'(ep));
    chk("idle_strobes",
        32'({bus.outValid, bus.outWrap, bus.outErr}), 32'd0);
    bus.inSyncClr = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin : stim
    bus.inData    = '0;
    bus.inValid   = 1'b0;
    bus.inMode    = MODE_ADDR;
    bus.inSel     = '0;
    bus.inSyncClr = 1'b0;
    #3;
    chk("rst_data", 32'(bus.outData), 32'd0);
    chk("rst_misc", 32'({bus.outValid, bus.outPtr, bus.outWrap,
                         bus.outErr}), 32'd0);
`ifdef DEMUX_ERR_CNT_EN
    chk("rst_errcnt", 32'(bus.outErrCnt), 32'd0);
`endif
    repeat (2) @(negedge inClk);
    inRst = 1'b0;

    send(MODE_SEQ, 2'd0, 3'd1, 1'b0, 3'b001, 9'b000_000_001, 1'b0, 1'b0, 2'd1);
    send(MODE_SEQ, 2'd0, 3'd6, 1'b0, 3'b010, 9'b000_110_001, 1'b0, 1'b0, 2'd2);
    send(MODE_SEQ, 2'd0, 3'd5, 1'b0, 3'b100, 9'b101_110_001, 1'b1, 1'b0, 2'd0);
    idle(1'b0, 2'd0);
    send(MODE_SEQ, 2'd0, 3'd2, 1'b0, 3'b001, 9'b101_110_010, 1'b0, 1'b0, 2'd1);
    send(MODE_ADDR, 2'd2, 3'd7, 1'b0, 3'b100, 9'b111_110_010, 1'b0, 1'b0, 2'd1);
    send(MODE_ADDR, 2'd0, 3'd3, 1'b0, 3'b001, 9'b111_110_011, 1'b0, 1'b0, 2'd1);
    repeat (3)
      send(MODE_ADDR, 2'd3, 3'd4, 1'b0, 3'b000, 9'b111_110_011, 1'b0, 1'b1, 2'd1);
    idle(1'b0, 2'd1);
`ifdef DEMUX_ERR_CNT_EN
    chk("errcnt_3", 32'(bus.outErrCnt), 32'd3);
`endif
    send(MODE_SEQ, 2'd0, 3'd4, 1'b0, 3'b010, 9'b111_100_011, 1'b0, 1'b0, 2'd2);
    send(MODE_ADDR, 2'd1, 3'd0, 1'b0, 3'b010, 9'b111_000_011, 1'b0, 1'b0, 2'd2);
    send(MODE_ADDR, 2'd0, 3'd5, 1'b0, 3'b001, 9'b111_000_101, 1'b0, 1'b0, 2'd2);
    send(MODE_SEQ, 2'd0, 3'd3, 1'b0, 3'b100, 9'b011_000_101, 1'b1, 1'b0, 2'd0);
    send(MODE_SEQ, 2'd0, 3'd1, 1'b0, 3'b001, 9'b011_000_001, 1'b0, 1'b0, 2'd1);
    send(MODE_SEQ, 2'd0, 3'd2, 1'b0, 3'b010, 9'b011_010_001, 1'b0, 1'b0, 2'd2);
    send(MODE_SEQ, 2'd0, 3'd6, 1'b1, 3'b001, 9'b011_010_110, 1'b0, 1'b0, 2'd1);
    idle(1'b1, 2'd0);
    send(MODE_SEQ, 2'd0, 3'd7, 1'b0, 3'b001, 9'b011_010_111, 1'b0, 1'b0, 2'd1);
    send(MODE_ADDR, 2'd2, 3'd4, 1'b1, 3'b100, 9'b100_010_111, 1'b0, 1'b0, 2'd0);
    send(MODE_SEQ, 2'd0, 3'd2, 1'b0, 3'b001, 9'b100_010_010, 1'b0, 1'b0, 2'd1);
    send(MODE_SEQ, 2'd3, 3'd3, 1'b0, 3'b010, 9'b100_011_010, 1'b0, 1'b0, 2'd2);
    quiet();

    @(negedge inClk);
    #2;
    inRst = 1'b1;
    #1;
    chk("midrst_data", 32'(bus.outData), 32'd0);
    chk("midrst_misc", 32'({bus.outValid, bus.outPtr, bus.outWrap,
                            bus.outErr}), 32'd0);
    @(negedge inClk);
    inRst = 1'b0;
    send(MODE_SEQ, 2'd0, 3'd5, 1'b0, 3'b001, 9'b000_000_101, 1'b0, 1'b0, 2'd1);
    idle(1'b0, 2'd1);

`ifdef DEMUX_ERR_CNT_EN
    repeat (300)
      send(MODE_ADDR, 2'd3, 3'd2, 1'b0, 3'b000, 9'b000_000_101, 1'b0, 1'b1, 2'd1);
    idle(1'b0, 2'd1);
    chk("errcnt_sat", 32'(bus.outErrCnt), 32'd255);
`endif

    repeat (3) @(negedge inClk);
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
